// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding instruction-memory read at a time,
// buffers up to two fetched words for decode, and steers the program counter.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    state_t      state, state_nxt;
    logic [1:0]  count, count_after;
    logic        wr_ptr, rd_ptr;
    logic [31:0] instr_q [2];
    logic [31:0] pc_q    [2];
    logic        push, pop;

    // The low two bits of a redirect target are forced to word alignment.
    wire unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    // A response is only kept when it answers a live request and no redirect
    // is squashing it in the same cycle.
    assign push        = (state == REQ) && imem_ack && !redirect_valid;
    assign pop         = if_valid && if_ready;
    assign count_after = count + {1'b0, push} - {1'b0, pop};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!redirect_valid && (count < FULL)) state_nxt = REQ;
            end
            REQ: begin
                if (redirect_valid)  state_nxt = imem_ack ? IDLE : DROP;
                else if (imem_ack)   state_nxt = (count_after < FULL) ? REQ : IDLE;
            end
            DROP: begin
                if (imem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == REQ);
        imem_addr = pc_cur;
        if (rst)                 pc_next = RESET_PC;
        else if (redirect_valid) pc_next = {redirect_pc[31:2], 2'b00};
        else if (push)           pc_next = pc_cur + 32'd4;
        else                     pc_next = pc_cur;
    end

    // NOTE: the two buffer entries are cleared on reset because the head entry
    // is visible on if_instr/if_pc and must read as zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= 32'd0;
                pc_q[i]    <= 32'd0;
            end
        end else if (redirect_valid) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                instr_q[wr_ptr] <= imem_rdata;
                pc_q[wr_ptr]    <= pc_cur;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_after;
        end
    end

    assign if_valid = (count != 2'd0);
    assign if_instr = instr_q[rd_ptr];
    assign if_pc    = pc_q[rd_ptr];

endmodule
